// File: rtl/sound_pkg.sv
// Shared definitions for the tone sequencer: sound types, FSM states, note pitches, melody lengths.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sound_pkg;

    // Sound type as produced by the upstream sound controller.
    typedef enum logic [1:0] {
        SND_RIGHT = 2'd0,
        SND_LEFT  = 2'd1,
        SND_SPEED = 2'd2,
        SND_NONE  = 2'd3
    } snd_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

    // Note frequencies in Hz.
    localparam int F_D4 = 294;
    localparam int F_G4 = 392;
    localparam int F_C5 = 523;
    localparam int F_E5 = 659;
    localparam int F_G5 = 784;
    localparam int F_A5 = 880;
    localparam int F_C6 = 1047;

    // Number of notes in each melody.
    localparam int MEL_LEN_RIGHT = 2;
    localparam int MEL_LEN_LEFT  = 2;
    localparam int MEL_LEN_SPEED = 4;
    localparam int MEL_LEN_NONE  = 0;

    // Square-wave half period in clock cycles, truncated, never below 1.
    function automatic int half_period(input int freq_hz, input int clk_hz);
        int h;
        h = clk_hz / (2 * freq_hz);
        if (h < 1) h = 1;
        return h;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [2:0] melody_len(input snd_t t);
        logic [2:0] len;
        case (t)
            SND_RIGHT: len = 3'(MEL_LEN_RIGHT);
            SND_LEFT:  len = 3'(MEL_LEN_LEFT);
            SND_SPEED: len = 3'(MEL_LEN_SPEED);
            default:   len = 3'(MEL_LEN_NONE);
        endcase
        return len;
    endfunction

endpackage

// File: rtl/square_divider.sv
// Square-wave generator: toggles wave every `half` cycles while run is high.
// Latency: first toggle `half` cycles after run rises (counter starts from a clear state).
// Backpressure: none; clr or !run forces wave low and restarts the count.
//
// Ports: clk, rst (async active-low), clr (restart), run (enable counting),
//        half (half period in cycles, 0 treated as 1), wave (registered output).
module square_divider #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         run,
    input  logic [W-1:0] half,
    output logic         wave
);

    logic [W-1:0] cnt_q;
    logic         wave_q;
    logic [W:0]   cnt_inc;

    // One extra bit so the compare cannot wrap at the top of the range.
    assign cnt_inc = {1'b0, cnt_q} + {{W{1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            wave_q <= 1'b0;
        end else if (clr || !run) begin
            cnt_q  <= '0;
            wave_q <= 1'b0;
        end else if (cnt_inc >= {1'b0, half}) begin
            cnt_q  <= '0;
            wave_q <= ~wave_q;
        end else begin
            cnt_q  <= cnt_inc[W-1:0];
        end
    end

    assign wave = wave_q;

endmodule

// File: rtl/tone_sequencer.sv
// Melody player: plays a fixed per-type note sequence as a square wave on audio.
// Latency: playback starts the cycle after enable is seen in IDLE; all outputs registered.
// Backpressure: none; enable low aborts to IDLE, DONE waits for enable low before re-arming.
//
// Ports: clk, rst (async active-low), enable (play request level), sound_type (0..3),
//        audio (square wave), busy (PLAY/GAP), done (1-cycle pulse at end of a one-shot melody).
module tone_sequencer
    import sound_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int NOTE_LEN = 6_250_000,
    parameter int GAP_LEN  = 625_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] sound_type,
    output logic       audio,
    output logic       busy,
    output logic       done
);

    // Pitch table resolved at elaboration.
    localparam int H_A5 = half_period(F_A5, CLK_HZ);
    localparam int H_E5 = half_period(F_E5, CLK_HZ);
    localparam int H_G4 = half_period(F_G4, CLK_HZ);
    localparam int H_D4 = half_period(F_D4, CLK_HZ);
    localparam int H_C5 = half_period(F_C5, CLK_HZ);
    localparam int H_G5 = half_period(F_G5, CLK_HZ);
    localparam int H_C6 = half_period(F_C6, CLK_HZ);

    localparam int H_MAX = max_int(max_int(max_int(H_A5, H_E5), max_int(H_G4, H_D4)),
                                   max_int(max_int(H_C5, H_G5), H_C6));
    localparam int CNT_MAX = max_int(max_int(NOTE_LEN, GAP_LEN), H_MAX);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LEN - 1);

    seq_state_t       state_q, state_d;
    snd_t             type_q, type_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] tmr_q, tmr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [CNT_W-1:0] half_sel;
    logic             last_note;
    logic             div_run;
    logic             div_clr;

    // Melody ROM: half period of the current note.
    always_comb begin
        half_sel = CNT_W'(1);
        case (type_q)
            SND_RIGHT: half_sel = (idx_q == 2'd0) ? CNT_W'(H_A5) : CNT_W'(H_E5);
            SND_LEFT:  half_sel = (idx_q == 2'd0) ? CNT_W'(H_G4) : CNT_W'(H_D4);
            SND_SPEED: begin
                case (idx_q)
                    2'd0:    half_sel = CNT_W'(H_C5);
                    2'd1:    half_sel = CNT_W'(H_E5);
                    2'd2:    half_sel = CNT_W'(H_G5);
                    default: half_sel = CNT_W'(H_C6);
                endcase
            end
            default:   half_sel = CNT_W'(1);
        endcase
    end

    assign last_note = ({1'b0, idx_q} + 3'd1) >= melody_len(type_q);

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        idx_d   = idx_q;
        tmr_d   = tmr_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tmr_d = '0;
                idx_d = 2'd0;
                if (enable) begin
                    type_d  = snd_t'(sound_type);
                    // The silent type finishes immediately without a done pulse.
                    state_d = (snd_t'(sound_type) == SND_NONE) ? ST_DONE : ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    tmr_d   = '0;
                    idx_d   = 2'd0;
                end else if (tmr_q == NOTE_LAST) begin
                    state_d = ST_GAP;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    tmr_d   = '0;
                    idx_d   = 2'd0;
                end else if (tmr_q == GAP_LAST) begin
                    tmr_d = '0;
                    if (!last_note) begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ST_PLAY;
                    end else if (type_q == SND_SPEED) begin
                        idx_d   = 2'd0;
                        state_d = ST_PLAY;
                    end else begin
                        idx_d   = 2'd0;
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_DONE: begin
                tmr_d = '0;
                idx_d = 2'd0;
                // Re-arm only once the controller drops enable.
                if (!enable) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_d = (state_d == ST_PLAY) || (state_d == ST_GAP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            type_q  <= SND_RIGHT;
            idx_q   <= 2'd0;
            tmr_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            idx_q   <= idx_d;
            tmr_q   <= tmr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // The divider only runs for cycles that stay in PLAY, so the wave is already
    // low on the first GAP cycle and every note restarts from a cleared count.
    assign div_run = (state_d == ST_PLAY);
    assign div_clr = (state_q != ST_PLAY);

    square_divider #(
        .W (CNT_W)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (div_clr),
        .run  (div_run),
        .half (half_sel),
        .wave (audio)
    );

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
module tb_tone_sequencer;

    localparam int CLK_HZ   = 8800;
    localparam int NOTE_LEN = 40;
    localparam int GAP_LEN  = 4;
    localparam int SLOT     = NOTE_LEN + GAP_LEN;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] sound_type = 2'd0;
    logic       audio;
    logic       busy;
    logic       done;

    tone_sequencer #(
        .CLK_HZ   (CLK_HZ),
        .NOTE_LEN (NOTE_LEN),
        .GAP_LEN  (GAP_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .sound_type (sound_type),
        .audio      (audio),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int done_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a melody is a sequence of fixed-length slots (note then gap);
    // everything is derived from the number of cycles elapsed since playback began.
    int m_mode = 0;   // 0 idle, 1 playing, 2 finished (waiting for enable low)
    int m_type = 0;
    int m_e    = 0;
    int m_done = 0;

    function automatic int ref_freq(input int t, input int slot);
        case (t)
            0: return (slot == 0) ? 880 : 659;
            1: return (slot == 0) ? 392 : 294;
            2: case (slot)
                   0: return 523;
                   1: return 659;
                   2: return 784;
                   default: return 1047;
               endcase
            default: return 1;
        endcase
    endfunction

    function automatic int ref_len(input int t);
        case (t)
            0: return 2;
            1: return 2;
            2: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic int ref_half(input int t, input int slot);
        int h;
        h = CLK_HZ / (2 * ref_freq(t, slot));
        return (h < 1) ? 1 : h;
    endfunction

    function automatic int exp_audio();
        int slot, off, h;
        if (m_mode != 1) return 0;
        slot = (m_e / SLOT) % ref_len(m_type);
        off  = m_e % SLOT;
        if (off >= NOTE_LEN) return 0;
        h = ref_half(m_type, slot);
        return (off / h) % 2;
    endfunction

    task automatic model_edge();
        m_done = 0;
        if (!rst) begin
            m_mode = 0;
            return;
        end
        case (m_mode)
            0: if (enable) begin
                   m_type = int'(sound_type);
                   m_e    = 0;
                   m_mode = (m_type == 3) ? 2 : 1;
               end
            1: if (!enable) begin
                   m_mode = 0;
               end else begin
                   m_e++;
                   if (m_type != 2 && m_e == ref_len(m_type) * SLOT) begin
                       m_mode = 2;
                       m_done = 1;
                   end
               end
            default: if (!enable) m_mode = 0;
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        if (done === 1'b1) done_seen++;
        check("audio", 32'(audio), 32'(exp_audio()));
        check("busy",  32'(busy),  32'(m_mode == 1));
        check("done",  32'(done),  32'(m_done));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int d0;

    initial begin
        // Reset state.
        run(3);
        rst = 1'b1;
        run(2);

        // Type 0, reset mid-note, restart with enable still high.
        sound_type = 2'd0;
        enable = 1'b1;
        run(30);
        #2;
        rst = 1'b0;
        m_mode = 0;
        #1;
        check("rst_audio", 32'(audio), 32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        run(2);
        rst = 1'b1;
        d0 = done_seen;
        run(2 * SLOT + 5);
        check("done_cnt_t0", 32'(done_seen - d0), 32'd1);
        // Held enable after completion stays silent.
        run(100);
        check("done_hold_t0", 32'(done_seen - d0), 32'd1);
        // One-cycle enable drop re-arms.
        enable = 1'b0;
        step();
        enable = 1'b1;
        run(2 * SLOT + 5);
        check("done_cnt_rearm", 32'(done_seen - d0), 32'd2);
        enable = 1'b0;
        run(3);

        // Type 1 with a type change mid-melody.
        sound_type = 2'd1;
        enable = 1'b1;
        run(20);
        sound_type = 2'd0;
        run(80);
        enable = 1'b0;
        run(3);

        // Type 2 loops without a done pulse.
        sound_type = 2'd2;
        enable = 1'b1;
        d0 = done_seen;
        run(300);
        check("done_cnt_t2", 32'(done_seen - d0), 32'd0);
        enable = 1'b0;
        run(3);

        // Type 3 is silent, then type 0 after re-arm.
        sound_type = 2'd3;
        enable = 1'b1;
        d0 = done_seen;
        run(20);
        check("done_cnt_t3", 32'(done_seen - d0), 32'd0);
        enable = 1'b0;
        step();
        sound_type = 2'd0;
        enable = 1'b1;
        run(20);
        enable = 1'b0;
        run(2);

        // Randomised sessions.
        for (int k = 0; k < 40; k++) begin
            sound_type = 2'($urandom_range(0, 3));
            enable = 1'b1;
            for (int c = 0, n = $urandom_range(1, 200); c < n; c++) begin
                step();
                if ($urandom_range(0, 19) == 0) sound_type = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 99) == 0) enable = ~enable;
            end
            enable = 1'b0;
            run($urandom_range(1, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Downstream audio stage of the sound controller. It consumes the controller's 2-bit sound type and its enable (notshutdown).
- Plays a short fixed melody per sound type as a square wave on the audio pin.
- Notes come from an internal melody ROM. Each note has fixed duration and is followed by an inter-note gap; the speed-round melody loops while enabled.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency used to derive pitch half-periods.
- NOTE_LEN, 6_250_000, clock cycles each note sounds (125 ms at default).
- GAP_LEN, 625_000, silent cycles after every note (12.5 ms at default).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- enable  input  1  play request (level), driven by the controller's notshutdown
- sound_type  input  2  0=right push, 1=left push, 2=speed round, 3=silent
- audio  output  1  square-wave audio to the amplifier
- busy  output  1  high in PLAY or GAP
- done  output  1  one-cycle pulse when a non-looping melody completes

Behaviour:
- Reset (rst low, async): state IDLE, audio=0, busy=0, done=0, note index=0, all counters 0.
- Melody ROM:
  - type 0: A5(880 Hz), E5(659).
  - type 1: G4(392), D4(294).
  - type 2: C5(523), E5(659), G5(784), C6(1047), looping.
  - type 3: empty.
- Half-period counts: half = CLK_HZ/(2*f), truncated, minimum 1. They are computed at elaboration, not in hardware.
- States:
  - IDLE, with enable=1: latch sound_type and go to PLAY, index 0. If the latched type is 3, go to DONE instead, with no done pulse.
  - PLAY: audio toggles every `half` cycles, starting low. The first toggle comes `half` cycles after entry. The note timer counts NOTE_LEN cycles, then the block enters GAP with audio forced to 0 on the next cycle.
  - GAP: audio=0 for GAP_LEN cycles, then:
    - If more notes remain: index+1 and back to PLAY, with the divider counter cleared.
    - Else if type 2 and enable=1: index=0, PLAY.
    - Else: go to DONE and pulse done for 1 cycle (type 0 or 1 only).
  - DONE: audio=0, busy=0. Stays in DONE until enable=0, then IDLE. This gives re-arm on an enable edge only, so there is no retrigger while the controller holds enable.
- enable falling in PLAY or GAP: abort. Next cycle the state is IDLE, audio=0, busy=0, no done pulse.
- sound_type changes while busy are ignored. The latched value governs until the block returns to IDLE.
- enable high during the same cycle that GAP ends for type 2: the melody loops. enable low in that cycle: abort rule wins, go to IDLE.
- Counters are sized with $clog2 of max(NOTE_LEN, GAP_LEN, largest half) and must not wrap within a note.
- All outputs are registered.

Decomposition:
- Package sound_pkg holds:
  - sound type constants (SND_RIGHT=0, SND_LEFT=1, SND_SPEED=2, SND_NONE=3);
  - note frequency constants;
  - melody length per type;
  - a function returning the half-period for a frequency and CLK_HZ.
- Sub-module square_divider: inputs clk, rst, clr, run, half; output wave. It toggles wave every `half` cycles while run=1 and forces wave low on clr or !run.
- tone_sequencer holds the FSM, the note and gap timers, and the ROM lookup.

Test Plan (CLK_HZ=8800, NOTE_LEN=40, GAP_LEN=4):
- Reset mid-note (rst low during PLAY of type 0) -> audio=0, busy=0, state IDLE at the same edge. After release with enable still high, the melody restarts at A5.
- enable=1, sound_type=0 -> A5 toggles every 5 cycles for 40 cycles, then 4 low, then E5 toggles every 6 cycles for 40. After the final gap, done pulses 1 cycle, busy=0, audio stays 0 while enable remains 1.
- sound_type=1 -> G4 half=11, D4 half=14. Change sound_type to 0 mid-melody -> no effect on pitch sequence.
- sound_type=2 held 300 cycles -> C5(8), E5(6), G5(5), C6(4) repeat with no done pulse. enable low -> audio 0 next cycle, busy 0.
- sound_type=3 with enable=1 -> audio stays 0, busy 0, done never pulses. enable 0 then 1 with type 0 -> plays A5.
- DONE re-arm: after type-0 completion, hold enable 1 for 100 cycles -> silence. Pulse enable 0 for 1 cycle, then 1 -> melody replays.
